conv_layer_sched: RTL

CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

---
 rtl/conv_layer_sched.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sched.sv
// conv_layer_sched
// Sequences one convolution layer across N_KER engines. For each kernel the
// engine is cleared for two cycles, the whole input map is streamed to it from
// the input RAM (one pixel per cycle), and its result strobes are written
// contiguously into the output RAM at ker_sel*OUT_PIX + n. A drain watchdog
// bounds the wait for the last result of each kernel.
//
// Ports
//   clk_in      clock, rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH despite its name
//   go          one-cycle layer request, honoured only when idle
//   rd_addr     input-map RAM read address (RAM answers one cycle later)
//   rd_data     signed input pixel from the RAM
//   map_in      registered pixel stream to the engine, 0 when not streaming
//   conv_start  engine enable, high from pixel 0 through the drain
//   conv_rst    engine synchronous clear
//   ker_sel     active engine / result mux select
//   save_in     engine result-valid strobe
//   result_in   engine result
//   wr_en/wr_addr/wr_data  output-map RAM write port (registered)
//   busy        high while a layer is in progress
//   done        one-cycle pulse when the layer completes
//   err         sticky drain-timeout flag, cleared by the next accepted go
`timescale 1ns/1ps
module conv_layer_sched #(
  parameter int IMG_PIX   = 9216,
  parameter int OUT_PIX   = 7744,
  parameter int N_KER     = 4,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       go,
  output logic [13:0]                rd_addr,
  input  logic [15:0]                rd_data,
  output logic [15:0]                map_in,
  output logic                       conv_start,
  output logic                       conv_rst,
  output logic [$clog2(N_KER)-1:0]   ker_sel,
  input  logic                       save_in,
  input  logic [15:0]                result_in,
  output logic                       wr_en,
  output logic [14:0]                wr_addr,
  output logic [15:0]                wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int KW = $clog2(N_KER);
  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  localparam logic [13:0]   LAST_ADDR  = 14'(IMG_PIX - 1);
  localparam logic [12:0]   OUT_FULL   = 13'(OUT_PIX);
  localparam logic [14:0]   OUT_STRIDE = 15'(OUT_PIX);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [KW-1:0] KER_LAST   = KW'(N_KER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            clr_cnt_q, clr_cnt_d;
  logic [13:0]     rd_addr_q, rd_addr_d;
  logic [KW-1:0]   ker_sel_q, ker_sel_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            err_q, err_d;
  logic [12:0]     out_cnt_q, out_cnt_d;
  logic            v1_q, v1_d;
  logic [15:0]     map_in_q, map_in_d;
  logic            conv_start_q, conv_start_d;
  logic            conv_rst_q, conv_rst_d;
  logic            wr_en_q, wr_en_d;
  logic [14:0]     wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            save_ok_s;
  logic            stream_s;

  // Next-state logic and the per-kernel sequencing counters.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rd_addr_d   = rd_addr_q;
    ker_sel_d   = ker_sel_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = CLR;
          ker_sel_d = {KW{1'b0}};
          err_d     = 1'b0;
          clr_cnt_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        rd_addr_d   = 14'd0;
        drain_cnt_d = {DW{1'b0}};
        // Two clear cycles: the flag marks the second one.
        if (clr_cnt_q) begin
          state_d   = FEED;
          clr_cnt_d = 1'b0;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      FEED: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = DRAIN;
          rd_addr_d = 14'd0;
        end else begin
          rd_addr_d = rd_addr_q + 14'd1;
        end
      end
      DRAIN: begin
        // A full result count wins over a watchdog expiring in the same cycle.
        if (out_cnt_q == OUT_FULL) begin
          state_d = NEXT;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = NEXT;
          err_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      NEXT: begin
        drain_cnt_d = {DW{1'b0}};
        if (ker_sel_q == KER_LAST) begin
          state_d = FIN;
        end else begin
          ker_sel_d = ker_sel_q + KW'(1);
          clr_cnt_d = 1'b0;
          state_d   = CLR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result acceptance, write port and the registered output decode.
  always_comb begin
    save_ok_s = save_in && ((state_q == FEED) || (state_q == DRAIN)) && (out_cnt_q < OUT_FULL);
    stream_s  = (state_d == FEED) || (state_d == DRAIN);

    if (state_q == CLR) begin
      out_cnt_d = 13'd0;
    end else if (save_ok_s) begin
      out_cnt_d = out_cnt_q + 13'd1;
    end else begin
      out_cnt_d = out_cnt_q;
    end

    wr_en_d = save_ok_s;
    if (save_ok_s) begin
      wr_addr_d = (15'(ker_sel_q) * OUT_STRIDE) + 15'(out_cnt_q);
      wr_data_d = result_in;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end

    // v1 marks the cycle in which rd_data answers an address issued in FEED;
    // map_in then lands two cycles after its address.
    v1_d = (state_q == FEED);
    if (stream_s && v1_q) begin
      map_in_d = rd_data;
    end else begin
      map_in_d = 16'd0;
    end
    // Rises with pixel 0 on map_in and holds until the drain ends.
    conv_start_d = stream_s && (v1_q || conv_start_q);

    conv_rst_d = (state_d == CLR);
    busy_d     = (state_d == CLR) || (state_d == FEED) || (state_d == DRAIN) || (state_d == NEXT);
    done_d     = (state_d == FIN);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      clr_cnt_q    <= 1'b0;
      rd_addr_q    <= 14'd0;
      ker_sel_q    <= {KW{1'b0}};
      drain_cnt_q  <= {DW{1'b0}};
      err_q        <= 1'b0;
      out_cnt_q    <= 13'd0;
      v1_q         <= 1'b0;
      map_in_q     <= 16'd0;
      conv_start_q <= 1'b0;
      conv_rst_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 15'd0;
      wr_data_q    <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      rd_addr_q    <= rd_addr_d;
      ker_sel_q    <= ker_sel_d;
      drain_cnt_q  <= drain_cnt_d;
      err_q        <= err_d;
      out_cnt_q    <= out_cnt_d;
      v1_q         <= v1_d;
      map_in_q     <= map_in_d;
      conv_start_q <= conv_start_d;
      conv_rst_q   <= conv_rst_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign map_in     = map_in_q;
  assign conv_start = conv_start_q;
  assign conv_rst   = conv_rst_q;
  assign ker_sel    = ker_sel_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
